// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
// Shared definitions for the timer family: the default counter width, the
// run-mode encodings captured on load and the two-state controller encoding.
// -----------------------------------------------------------------------------
package down_timer_pkg;

   // Default counter / load-value width in bits (must be >= 2).
   localparam int unsigned DEFAULT_WIDTH = 4;

   // Mode encodings, sampled from the mode input only on a load cycle.
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Controller states.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_t;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable down-counter with a one-cycle terminal-count pulse. After a load
// with a non-zero value the timer runs, decrementing once per enabled clock.
// On the enabled edge that leaves 1 behind it raises tc for one cycle and then
// either stops at 0 (one-shot) or reloads the captured start value (periodic).
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset, highest priority
//   enable     in   count enable, one decrement per cycle while high
//   load       in   load strobe, samples load_value and mode; beats enable
//   load_value in   start / reload value (WIDTH bits)
//   mode       in   0 = one-shot, 1 = periodic; captured only on load
//   out        out  current count (registered)
//   tc         out  terminal-count pulse, one cycle wide (registered)
//   busy       out  high while the controller is in RUN (registered)
// -----------------------------------------------------------------------------
module down_timer
   import down_timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             mode,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   // State registers
   timer_state_t     r_state;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_reload;
   logic             r_mode;
   logic             r_tc;
   logic             r_busy;

   // Next-state values
   timer_state_t     w_state_nxt;
   logic [WIDTH-1:0] w_out_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_mode_nxt;
   logic             w_tc_nxt;
   logic             w_busy_nxt;

   // Next-state / next-count / terminal-count decode.
   always_comb begin
      w_state_nxt  = r_state;
      w_out_nxt    = r_out;
      w_reload_nxt = r_reload;
      w_mode_nxt   = r_mode;
      w_tc_nxt     = 1'b0;

      if (load) begin
         // Load overrides counting in any state; a zero load parks the timer
         // in IDLE so no terminal count is ever produced for it.
         w_out_nxt    = load_value;
         w_reload_nxt = load_value;
         w_mode_nxt   = mode;
         w_state_nxt  = (load_value != CNT_ZERO) ? RUN : IDLE;
      end else begin
         case (r_state)
            RUN: begin
               if (enable) begin
                  if (r_out > CNT_ONE) begin
                     // Decrement only from 2 upward, so underflow cannot occur.
                     w_out_nxt = r_out - CNT_ONE;
                  end else if (r_out == CNT_ONE) begin
                     // Terminal edge: pulse tc, then stop or restart.
                     w_tc_nxt = 1'b1;
                     if (r_mode == MODE_PERIODIC) begin
                        w_out_nxt = r_reload;
                     end else begin
                        w_out_nxt   = CNT_ZERO;
                        w_state_nxt = IDLE;
                     end
                  end else begin
                     // A zero count in RUN is unreachable; fall back to IDLE.
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_out_nxt = r_out;
               end
            end
            IDLE: begin
               // IDLE holds the count; there is no wrap from 0.
               w_out_nxt = r_out;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end

      w_busy_nxt = (w_state_nxt == RUN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_out    <= CNT_ZERO;
         r_reload <= CNT_ZERO;
         r_mode   <= MODE_ONESHOT;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_out    <= w_out_nxt;
         r_reload <= w_reload_nxt;
         r_mode   <= w_mode_nxt;
         r_tc     <= w_tc_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign out  = r_out;
   assign tc   = r_tc;
   assign busy = r_busy;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
// Directed-vector bench for down_timer (WIDTH=4). Inputs change on the falling
// edge, outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_down_timer;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       load;
   logic [3:0] load_value;
   logic       mode;
   logic [3:0] out;
   logic       tc;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int tc_count;

   down_timer #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .mode       (mode),
      .out        (out),
      .tc         (tc),
      .busy       (busy)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample after the rising edge.
   task automatic cyc(input logic r, input logic l, input logic [3:0] v,
                      input logic m, input logic e);
      reset      = r;
      load       = l;
      load_value = v;
      mode       = m;
      enable     = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect3(input string tag, input int e_out, input int e_tc,
                          input int e_busy);
      chk({tag, ".out"},  int'(out),  e_out);
      chk({tag, ".tc"},   int'(tc),   e_tc);
      chk({tag, ".busy"}, int'(busy), e_busy);
   endtask

   initial begin
      int exp_out_os[5];
      int exp_out_pe[10];
      int exp_out_gt[8];
      exp_out_os = '{4, 3, 2, 1, 0};
      exp_out_pe = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
      exp_out_gt = '{3, 3, 2, 2, 1, 1, 0, 0};

      reset = 1'b0; load = 1'b0; load_value = 4'd0; mode = 1'b0; enable = 1'b0;
      @(negedge clk);

      // Reset beats simultaneous load and enable.
      cyc(1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
      expect3("reset", 0, 0, 0);

      // One-shot load 5: 5,4,3,2,1,0 with tc and busy drop on the 0 cycle.
      cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
      expect3("os_load", 5, 0, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
         expect3($sformatf("os_%0d", i), exp_out_os[i], (i == 4) ? 1 : 0,
                 (i == 4) ? 0 : 1);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
         expect3($sformatf("os_hold_%0d", i), 0, 0, 0);
      end

      // Periodic load 3, ten enabled cycles: tc on each reload to 3.
      cyc(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
      expect3("pe_load", 3, 0, 1);
      tc_count = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
         expect3($sformatf("pe_%0d", i), exp_out_pe[i],
                 (exp_out_pe[i] == 3) ? 1 : 0, 1);
         if (tc) tc_count++;
      end
      chk("pe_tc_count", tc_count, 3);

      // Periodic load 1: tc on every enabled cycle, out stays 1.
      cyc(1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
      expect3("pe1_load", 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
         expect3($sformatf("pe1_%0d", i), 1, 1, 1);
      end

      // Enable gating: one-shot 4 with enable toggling 1,0,1,0,...
      cyc(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
      expect3("gate_load", 4, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
         expect3($sformatf("gate_%0d", i), exp_out_gt[i], (i == 6) ? 1 : 0,
                 (i >= 6) ? 0 : 1);
      end

      // Load coincident with the terminal cycle wins.
      cyc(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
      expect3("pri_load", 2, 0, 1);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      expect3("pri_dec", 1, 0, 1);
      cyc(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
      expect3("pri_term_load", 7, 0, 1);

      // Load 0: idle, no tc ever.
      cyc(1'b0, 1'b1, 4'd0, 1'b1, 1'b1);
      expect3("zero_load", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
         expect3($sformatf("zero_%0d", i), 0, 0, 0);
      end

      // Reset mid-run: load 15, count to 9, reset, then no counting.
      cyc(1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
      expect3("rst_load", 15, 0, 1);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      end
      expect3("rst_pre", 9, 0, 1);
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      expect3("rst_mid", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
         expect3($sformatf("rst_after_%0d", i), 0, 0, 0);
      end

      // Mode input changed after load is ignored: stays one-shot.
      cyc(1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
      expect3("mode_load", 2, 0, 1);
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      expect3("mode_dec", 1, 0, 1);
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      expect3("mode_term", 0, 1, 0);
      cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      expect3("mode_after", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_down_timer
